// File: rtl/meas_sched_pkg.sv
// Shared types and sizing helpers for the measurement scheduler.
package meas_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    LOAD    = 3'd2,
    SETTLE  = 3'd3,
    CONVERT = 3'd4,
    RESPOND = 3'd5
  } state_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Widths for the default configuration.
  localparam int SETTLE_W_DEF  = cnt_w(16);
  localparam int TIMEOUT_W_DEF = cnt_w(255);
  localparam int IDX_W_DEF     = cnt_w(4);

endpackage

// File: rtl/meas_scheduler_rr_arbiter.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, take the lowest set
// bit, then rotate the index back. Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: N];

  // Priority-encode the rotated vector, then map back to a channel index.
  always_comb begin
    int off;
    int s;
    off   = 0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        off   = k;
        o_any = 1'b1;
      end
    end
    s = int'(i_ptr) + off;
    if (s >= N) s = s - N;
    o_idx = IW'(s);
    o_gnt = '0;
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/meas_scheduler.sv
// Time-shares one DAC/ADC chain between N_CH requesters, round-robin.
// Optional ADC conversion timeout is compiled in with MEAS_TIMEOUT_EN.
module meas_scheduler
  import meas_sched_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int BUS_WIDTH   = 10,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH*BUS_WIDTH-1:0] i_ref_in,
  output logic [N_CH-1:0]           grant,
  output logic [N_CH-1:0]           ready,
  output logic [BUS_WIDTH-1:0]      q_measured,
  output logic [BUS_WIDTH-1:0]      dac_code,
  output logic                      dac_load,
  output logic                      adc_start,
  input  logic                      adc_done,
  input  logic [BUS_WIDTH-1:0]      adc_data,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IW = cnt_w(N_CH);
  localparam int SW = cnt_w(SETTLE_CYC);

  state_t                r_state, w_next;
  logic [IW-1:0]         r_ptr;
  logic [N_CH-1:0]       r_grant;
  logic [BUS_WIDTH-1:0]  r_dac, r_adc, r_q;
  logic [SW-1:0]         r_scnt;
  logic                  r_first;
  logic [N_CH-1:0]       w_pick;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_done_ok;
  logic                  w_resp_ok;
  logic                  w_tmo;

  rr_arbiter #(.N(N_CH), .IW(IW)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // A done pulse coinciding with adc_start belongs to nothing we launched.
  assign w_done_ok = (r_state == CONVERT) && adc_done && !r_first;
  // Result is delivered only if the owner is still asking for it.
  assign w_resp_ok = (r_state == RESPOND) && |(req & r_grant);

`ifdef MEAS_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYC);
  logic [TW-1:0] r_tcnt;
  logic          r_terr;

  assign w_tmo       = (r_state == CONVERT) && !w_done_ok &&
                       (r_tcnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_err = r_terr;

  // Conversion watchdog; error flag stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end else begin
      r_tcnt <= (r_state == CONVERT) ? r_tcnt + 1'b1 : '0;
      if (w_tmo) r_terr <= 1'b1;
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable && |req) w_next = ARB;
      ARB:     w_next = w_any ? LOAD : IDLE;
      LOAD:    w_next = SETTLE;
      SETTLE:  if (r_scnt == SW'(SETTLE_CYC - 1)) w_next = CONVERT;
      CONVERT: if (w_done_ok || w_tmo) w_next = RESPOND;
      RESPOND: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath latches: grant/code capture, settle count, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_dac   <= '0;
      r_adc   <= '0;
      r_q     <= '0;
      r_scnt  <= '0;
      r_first <= 1'b0;
    end else begin
      r_first <= (r_state == SETTLE) && (w_next == CONVERT);
      case (r_state)
        ARB: if (w_any) begin
          r_grant <= w_pick;
          r_dac   <= i_ref_in[w_idx*BUS_WIDTH +: BUS_WIDTH];
          r_ptr   <= (w_idx == IW'(N_CH - 1)) ? '0 : w_idx + 1'b1;
        end
        LOAD:    r_scnt <= '0;
        SETTLE:  r_scnt <= r_scnt + 1'b1;
        CONVERT: begin
          if (w_done_ok)  r_adc <= adc_data;
          else if (w_tmo) r_adc <= '1;
        end
        RESPOND: begin
          r_grant <= '0;
          if (w_resp_ok) r_q <= r_adc;
        end
        default: ;
      endcase
    end
  end

  // Grant shows the arbiter pick already in ARB so the owner sees it at once.
  assign grant      = (r_state == ARB) ? w_pick : r_grant;
  assign ready      = w_resp_ok ? r_grant : '0;
  assign q_measured = w_resp_ok ? r_adc : r_q;
  assign dac_code   = r_dac;
  assign dac_load   = (r_state == LOAD);
  assign adc_start  = (r_state == CONVERT) && r_first;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_meas_scheduler.sv
// Self-checking bench for meas_scheduler: directed scenarios plus a random
// request/ADC-timing loop checked against a round-robin reference model.
module tb_meas_scheduler;

  localparam int N  = 4;
  localparam int BW = 10;
  localparam int S  = 16;
  localparam int T  = 255;

  logic              clk = 1'b0;
  logic              rst, enable, adc_done;
  logic [N-1:0]      req, grant, ready;
  logic [N*BW-1:0]   i_ref_in;
  logic [BW-1:0]     q_measured, dac_code, adc_data;
  logic              dac_load, adc_start, busy, timeout_err;

  int tests = 0;
  int fails = 0;
  int ptr_m;
  logic [BW-1:0] q_m;

  meas_scheduler #(.N_CH(N), .BUS_WIDTH(BW), .SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .i_ref_in(i_ref_in),
    .grant(grant), .ready(ready), .q_measured(q_measured), .dac_code(dac_code),
    .dac_load(dac_load), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First requesting channel at or after ptr, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++)
      if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic scramble_refs();
    for (int k = 0; k < N; k++) i_ref_in[k*BW +: BW] = BW'($urandom);
  endtask

  // Drive one full transaction from IDLE (lat=2) or ARB (lat=1) and check it.
  task automatic serve(input int lat, input int c, input logic [BW-1:0] d,
                       input bit withdraw, input bit glitch, input bit endrop,
                       output int och);
    int ch, n;
    bit exp_rdy;
    logic [BW-1:0] code;
    ch  = pick(req, ptr_m);
    och = ch;
    chk("pick_valid", (ch >= 0), 1);
    if (ch < 0) return;
    code = i_ref_in[ch*BW +: BW];
    n = 0;
    while (dac_load !== 1'b1 && n < 8) begin step(); n++; end
    chk("load_lat", n, lat);
    chk("grant", grant, 1 << ch);
    chk("dac_code", dac_code, code);
    chk("busy", busy, 1);
    ptr_m = (ch + 1) % N;
    scramble_refs();
    n = 0;
    while (adc_start !== 1'b1 && n < S + 6) begin
      step(); n++;
      if (glitch && n == 2) begin adc_done = 1'b1; adc_data = ~d; end
      else adc_done = 1'b0;
      if (withdraw && n == 3) req[ch] = 1'b0;
      if (endrop && n == 4) enable = 1'b0;
    end
    chk("settle_lat", n, S + 1);
    chk("dac_hold", dac_code, code);
    exp_rdy = req[ch];
    if (glitch) begin adc_done = 1'b1; adc_data = ~d; end
    step();
    adc_done = 1'b0;
    repeat (c - 1) step();
    adc_done = 1'b1; adc_data = d;
    step();
    adc_done = 1'b0;
    if (exp_rdy) q_m = d;
    chk("ready", ready, exp_rdy ? (1 << ch) : 0);
    chk("q_resp", q_measured, q_m);
    chk("grant_resp", grant, 1 << ch);
    step();
    chk("ready_off", ready, 0);
    chk("idle", busy, 0);
    chk("q_hold", q_measured, q_m);
  endtask

  initial begin
    int n, och;
    logic [BW-1:0] d;
    rst = 1'b1; enable = 1'b0; req = '0; i_ref_in = '0;
    adc_done = 1'b0; adc_data = '0;
    step(); step();
    chk("rst_grant", grant, 0);   chk("rst_ready", ready, 0);
    chk("rst_q", q_measured, 0);  chk("rst_dac", dac_code, 0);
    chk("rst_load", dac_load, 0); chk("rst_start", adc_start, 0);
    chk("rst_busy", busy, 0);     chk("rst_terr", timeout_err, 0);
    rst = 1'b0; enable = 1'b1; ptr_m = 0; q_m = '0;

    // Single request on ch2.
    i_ref_in[2*BW +: BW] = 10'h155;
    req = 4'b0100;
    serve(2, 5, 10'h0AA, 0, 0, 0, och);
    chk("single_ch", och, 2);
    req = '0; step();

    // Contention from a fresh reset: 0,1,2,3,0.
    rst = 1'b1; step(); rst = 1'b0; ptr_m = 0; q_m = '0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(2, 3, BW'($urandom), 0, 0, 0, och);
      chk("rr_order", och, i % N);
    end

    // ch1 withdraws during SETTLE, then ch0 is served.
    req = 4'b0011;
    serve(2, 4, BW'($urandom), 1, 0, 0, och);
    chk("wd_ch", och, 1);
    serve(2, 2, BW'($urandom), 0, 0, 0, och);
    chk("wd_next", och, 0);
    req = '0; step();

    // Reset in CONVERT, then ch0 priority with ch3 also requesting.
    req = 4'b1000;
    n = 0;
    while (adc_start !== 1'b1 && n < 40) begin step(); n++; end
    chk("t4_conv", adc_start, 1);
    step(); step();
    rst = 1'b1; #1;
    chk("mid_grant", grant, 0); chk("mid_ready", ready, 0);
    chk("mid_busy", busy, 0);   chk("mid_dac", dac_code, 0);
    chk("mid_q", q_measured, 0); chk("mid_start", adc_start, 0);
    step(); rst = 1'b0; ptr_m = 0; q_m = '0;
    req = 4'b1001;
    serve(2, 3, BW'($urandom), 0, 0, 0, och);
    chk("post_rst_ch", och, 0);
    req = 4'b1000;
    serve(2, 3, BW'($urandom), 0, 0, 0, och);
    chk("post_rst_ch3", och, 3);
    req = '0; step();

    // Enable gating, and enable dropping mid-transaction.
    enable = 1'b0; req = 4'b0011;
    repeat (3) begin
      step();
      chk("en0_grant", grant, 0);
      chk("en0_busy", busy, 0);
    end
    enable = 1'b1; step();
    chk("en_grant", grant, 4'b0001);
    serve(1, 2, BW'($urandom), 0, 0, 1, och);
    req[0] = 1'b0;
    step();
    chk("endrop_busy", busy, 0);
    chk("endrop_grant", grant, 0);
    enable = 1'b1;
    serve(2, 2, BW'($urandom), 0, 1, 0, och);
    chk("en_ch1", och, 1);
    req = '0; step();

    // Random requests, ADC timing, withdrawals and stray done pulses.
    for (int i = 0; i < 40; i++) begin
      req = req | N'($urandom_range(0, (1 << N) - 1));
      if (req == '0) req = N'(1 << $urandom_range(0, N - 1));
      scramble_refs();
      d = BW'($urandom);
      serve(2, $urandom_range(1, 6), d, ($urandom % 5) == 0,
            ($urandom % 3) == 0, 0, och);
      if (och >= 0) req[och] = 1'b0;
    end
    req = '0; step();

    // ADC never answers.
    req = 4'b0100;
    n = 0;
    while (adc_start !== 1'b1 && n < 40) begin step(); n++; end
    chk("to_start", adc_start, 1);
`ifdef MEAS_TIMEOUT_EN
    repeat (T) step();
    chk("to_ready", ready, 4'b0100);
    chk("to_q", q_measured, 10'h3FF);
    chk("to_err", timeout_err, 1);
    step();
    chk("to_sticky", timeout_err, 1);
    chk("to_idle", busy, 0);
`else
    repeat (300) step();
    chk("hang_busy", busy, 1);
    chk("hang_terr", timeout_err, 0);
    chk("hang_ready", ready, 0);
`endif
    rst = 1'b1; req = '0; step(); rst = 1'b0;
    chk("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
